// File: rtl/uart_rx_frame_receiver.sv
// Oversampling UART receiver: recovers start/data/parity/stop from RX_IN using a
// 3-tap majority vote around mid-bit and emits the word with a one-cycle strobe.
module uart_rx_frame_receiver #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [5:0]            Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int unsigned CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                  state, state_nxt;
  logic [5:0]              p_lat;
  logic                    par_en_lat, par_typ_lat;
  logic [5:0]              edge_cnt;
  logic [CW-1:0]           bit_cnt;
  logic [1:0]              early;
  logic                    bit_q;
  logic [DATA_WIDTH-1:0]   shift_reg;
  logic                    par_bad;

  logic [5:0] p_cfg;
  logic [5:0] half;
  logic       last_tick;
  logic       start_det;
  logic       glitch;

  always_comb begin
    p_cfg = 6'd8;
    if (Prescale == 6'd8 || Prescale == 6'd16 || Prescale == 6'd32)
      p_cfg = Prescale;
  end

  assign half      = {1'b0, p_lat[5:1]};
  assign last_tick = (edge_cnt == p_lat - 6'd1);
  // A low line in the stop bit's last tick doubles as tick 0 of the next start bit.
  assign start_det = ((state == IDLE) && !RX_IN) ||
                     ((state == STOP) && last_tick && !RX_IN);
  assign glitch    = (state == START) && (edge_cnt == half + 6'd2) && bit_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (!RX_IN) state_nxt = START;
      START: begin
        if (glitch)         state_nxt = IDLE;
        else if (last_tick) state_nxt = DATA;
      end
      DATA:
        if (last_tick && (bit_cnt == CW'(DATA_WIDTH - 1)))
          state_nxt = par_en_lat ? PARITY : STOP;
      PARITY: if (last_tick) state_nxt = STOP;
      STOP:   if (last_tick) state_nxt = RX_IN ? IDLE : START;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      p_lat       <= 6'd8;
      par_en_lat  <= 1'b0;
      par_typ_lat <= 1'b0;
      edge_cnt    <= '0;
      bit_cnt     <= '0;
      early       <= '1;
      bit_q       <= 1'b1;
      shift_reg   <= '0;
      par_bad     <= 1'b0;
      P_DATA      <= '0;
      data_valid  <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
    end else begin
      data_valid <= 1'b0;

      if (start_det) begin
        p_lat       <= p_cfg;
        par_en_lat  <= PAR_EN;
        par_typ_lat <= PAR_TYP;
        edge_cnt    <= 6'd1;
        bit_cnt     <= '0;
        par_bad     <= 1'b0;
      end else if ((state == IDLE) || glitch) begin
        edge_cnt <= '0;
      end else if (last_tick) begin
        edge_cnt <= '0;
        if (state == DATA) bit_cnt <= bit_cnt + CW'(1);
      end else begin
        edge_cnt <= edge_cnt + 6'd1;
      end

      if (edge_cnt == half - 6'd1) early[0] <= RX_IN;
      if (edge_cnt == half)        early[1] <= RX_IN;
      if (edge_cnt == half + 6'd1)
        bit_q <= (early[0] & early[1]) | (early[0] & RX_IN) | (early[1] & RX_IN);

      if ((state == DATA) && last_tick)
        shift_reg <= {bit_q, shift_reg[DATA_WIDTH-1:1]};

      if ((state == PARITY) && last_tick)
        par_bad <= bit_q ^ (^shift_reg) ^ par_typ_lat;

      if ((state == STOP) && last_tick) begin
        par_err <= par_bad;
        stp_err <= ~bit_q;
        if (!par_bad && bit_q) begin
          P_DATA     <= shift_reg;
          data_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_receiver.sv
// Scoreboard bench for uart_rx_frame_receiver: frame drivers push expected completions,
// a negedge monitor checks them at their due cycle and flags any stray strobe.
module tb_uart_rx_frame_receiver;

  logic       CLK;
  logic       RST;
  logic       RX_IN;
  logic [5:0] Prescale;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  uart_rx_frame_receiver #(.DATA_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .P_DATA(P_DATA),
    .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err)
  );

  typedef struct {
    int         due;
    logic       valid;
    logic [7:0] data;
    logic       pe;
    logic       se;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc     = 0;
  int   n_pass  = 0;
  int   n_total = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge CLK) begin
    if (sb.size() != 0 && sb[0].due == cyc) begin
      mon_e = sb.pop_front();
      chk("data_valid", 32'(data_valid), 32'(mon_e.valid));
      chk("P_DATA",     32'(P_DATA),     32'(mon_e.data));
      chk("par_err",    32'(par_err),    32'(mon_e.pe));
      chk("stp_err",    32'(stp_err),    32'(mon_e.se));
    end else if (data_valid) begin
      n_total++;
      $display("FAIL stray_strobe: data_valid=1 at cycle %0d, required 0", cyc);
    end
  end

  task automatic drive(input logic b, input int n);
    RX_IN = b;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // p is the bit period driven on the line; gbit (>=0) inverts that data bit for one mid-bit cycle.
  task automatic send_frame(input logic [7:0] d, input int p, input logic pe, input logic pbit,
                            input logic sbit, input int gbit, input logic ev,
                            input logic [7:0] ed, input logic epe, input logic ese);
    exp_t e;
    e.due   = cyc + (2 + 8 + int'(pe)) * p;
    e.valid = ev;
    e.data  = ed;
    e.pe    = epe;
    e.se    = ese;
    sb.push_back(e);
    drive(1'b0, p);
    for (int i = 0; i < 8; i++) begin
      if (i == gbit) begin
        drive(d[i], p / 2);
        drive(~d[i], 1);
        drive(d[i], p - p / 2 - 1);
      end else begin
        drive(d[i], p);
      end
    end
    if (pe) drive(pbit, p);
    drive(sbit, p);
  endtask

  initial begin
    RST = 1'b0; RX_IN = 1'b1; Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_P_DATA",     32'(P_DATA),     32'h0);
    chk("rst_data_valid", 32'(data_valid), 32'h0);
    chk("rst_par_err",    32'(par_err),    32'h0);
    chk("rst_stp_err",    32'(stp_err),    32'h0);
    RST = 1'b1;
    drive(1'b1, 4);

    // P=8, even parity
    Prescale = 6'd8; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1, -1, 1'b1, 8'hA5, 1'b0, 1'b0);
    drive(1'b1, 8);
    send_frame(8'hA5, 8, 1'b1, 1'b1, 1'b1, -1, 1'b0, 8'hA5, 1'b1, 1'b0);
    drive(1'b1, 8);
    PAR_TYP = 1'b1;
    send_frame(8'hA5, 8, 1'b1, 1'b1, 1'b1, -1, 1'b1, 8'hA5, 1'b0, 1'b0);
    drive(1'b1, 8);

    // P=16, no parity, bad stop then clean
    Prescale = 6'd16; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b0, -1, 1'b0, 8'hA5, 1'b0, 1'b1);
    drive(1'b1, 32);
    send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b1, -1, 1'b1, 8'h3C, 1'b0, 1'b0);
    drive(1'b1, 16);

    // start glitch at P=8; next start lands one cycle after the return to IDLE
    Prescale = 6'd8;
    drive(1'b0, 2);
    drive(1'b1, 5);
    chk("glitch_P_DATA",     32'(P_DATA),     32'h3C);
    chk("glitch_par_err",    32'(par_err),    32'h0);
    chk("glitch_stp_err",    32'(stp_err),    32'h0);
    chk("glitch_data_valid", 32'(data_valid), 32'h0);
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1, -1, 1'b1, 8'h81, 1'b0, 1'b0);
    drive(1'b1, 8);

    // back-to-back at P=32 with parity, mid-bit glitch on bit 1 of the second frame
    Prescale = 6'd32; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    send_frame(8'h55, 32, 1'b1, 1'b0, 1'b1, -1, 1'b1, 8'h55, 1'b0, 1'b0);
    send_frame(8'hAA, 32, 1'b1, 1'b0, 1'b1, 1, 1'b1, 8'hAA, 1'b0, 1'b0);
    drive(1'b1, 64);

    // reset in the middle of the data bits of 0xFF
    Prescale = 6'd8; PAR_EN = 1'b0;
    drive(1'b0, 8);
    drive(1'b1, 24);
    RST = 1'b0;
    #1;
    chk("midrst_P_DATA",     32'(P_DATA),     32'h0);
    chk("midrst_data_valid", 32'(data_valid), 32'h0);
    chk("midrst_par_err",    32'(par_err),    32'h0);
    chk("midrst_stp_err",    32'(stp_err),    32'h0);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    drive(1'b1, 16);
    send_frame(8'h12, 8, 1'b0, 1'b0, 1'b1, -1, 1'b1, 8'h12, 1'b0, 1'b0);
    drive(1'b1, 8);

    // illegal Prescale falls back to 8
    Prescale = 6'd20;
    send_frame(8'h6B, 8, 1'b0, 1'b0, 1'b1, -1, 1'b1, 8'h6B, 1'b0, 1'b0);
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge CLK);
    drive(1'b1, 16);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
